regfile_wb_arbiter: RTL

- Owns the single write port of the 32x32 integer register file in the five-stage pipeline.
- Arbitrates that port between the in-order pipeline writeback and the long-latency multiply/divide unit (MDU) writeback.
- Keeps a per-register scoreboard of outstanding MDU destinations and raises an ID-stage hazard stall on RAW/WAW conflicts with them.
- Sits between the WB stage, the MDU result interface, the ID stage and the register file.

---
 rtl/regfile_wb_arbiter_if.sv | 52 +++++
 rtl/regfile_wb_arbiter.sv | 88 ++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter_if.sv
// Bus bundle for the register-file write-port arbiter: WB and MDU writeback
// handshakes, MDU issue tracking, the ID hazard query and the register file write port.
interface regfile_wb_arbiter_if;
  logic        pipe_wb_valid;
  logic [4:0]  pipe_wb_rd;
  logic [31:0] pipe_wb_data;
  logic        pipe_wb_ready;

  logic        mdu_wb_valid;
  logic [4:0]  mdu_wb_rd;
  logic [31:0] mdu_wb_data;
  logic        mdu_wb_ready;

  logic        issue_valid;
  logic [4:0]  issue_rd;

  logic        id_valid;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic [4:0]  id_rd;
  logic        id_uses_rd;
  logic        hazard_stall;

  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [31:0] busy_mask;

  // Surrounding pipeline / MDU / register file side.
  modport master (
    output pipe_wb_valid, pipe_wb_rd, pipe_wb_data,
    input  pipe_wb_ready,
    output mdu_wb_valid, mdu_wb_rd, mdu_wb_data,
    input  mdu_wb_ready,
    output issue_valid, issue_rd,
    output id_valid, id_rs1, id_rs2, id_rd, id_uses_rd,
    input  hazard_stall,
    input  rf_we, rf_waddr, rf_wdata, busy_mask
  );

  // Arbiter side.
  modport slave (
    input  pipe_wb_valid, pipe_wb_rd, pipe_wb_data,
    output pipe_wb_ready,
    input  mdu_wb_valid, mdu_wb_rd, mdu_wb_data,
    output mdu_wb_ready,
    input  issue_valid, issue_rd,
    input  id_valid, id_rs1, id_rs2, id_rd, id_uses_rd,
    output hazard_stall,
    output rf_we, rf_waddr, rf_wdata, busy_mask
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Register file write-port arbiter: shares the single write port between the
// in-order WB stage and the MDU, tracks outstanding MDU destinations and
// stalls ID on RAW/WAW conflicts with them.
module regfile_wb_arbiter #(
  parameter int unsigned STARVE_LIMIT = 3  // legal range 1..15
) (
  input logic                  clk,
  input logic                  rst_n,
  regfile_wb_arbiter_if.slave  bus
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0]  wait_cnt_q, wait_cnt_d;
  logic [31:0] sb_q, sb_d;
  logic        starved;
  logic        pipe_gnt;
  logic        mdu_gnt;
  logic [4:0]  gnt_rd;
  logic [31:0] gnt_data;
  logic        hazard;

  // Arbitration: pipeline wins unless the MDU has waited STARVE_LIMIT cycles.
  always_comb begin
    starved  = (wait_cnt_q >= LIMIT);
    pipe_gnt = bus.pipe_wb_valid & ~(bus.mdu_wb_valid & starved);
    mdu_gnt  = bus.mdu_wb_valid & ~pipe_gnt;
    gnt_rd   = 5'd0;
    gnt_data = 32'd0;
    if (pipe_gnt) begin
      gnt_rd   = bus.pipe_wb_rd;
      gnt_data = bus.pipe_wb_data;
    end else if (mdu_gnt) begin
      gnt_rd   = bus.mdu_wb_rd;
      gnt_data = bus.mdu_wb_data;
    end
  end

  // Next state of the starvation counter and the MDU scoreboard.
  always_comb begin
    if (!bus.mdu_wb_valid || mdu_gnt) begin
      wait_cnt_d = 4'd0;
    end else if (wait_cnt_q < LIMIT) begin
      wait_cnt_d = wait_cnt_q + 4'd1;
    end else begin
      wait_cnt_d = wait_cnt_q;
    end

    sb_d = sb_q;
    // The clear is applied first so that a same-cycle set of the same bit wins.
    if (mdu_gnt) begin
      sb_d[bus.mdu_wb_rd] = 1'b0;
    end
    if (bus.issue_valid && (bus.issue_rd != 5'd0)) begin
      sb_d[bus.issue_rd] = 1'b1;
    end
    sb_d[0] = 1'b0;
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments here so every register samples the
    // pre-edge values computed by the combinational blocks above.
    if (!rst_n) begin
      wait_cnt_q <= 4'd0;
      sb_q       <= 32'd0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      sb_q       <= sb_d;
    end
  end

  // Outputs: hazard check on the registered scoreboard, all forced low in reset.
  always_comb begin
    hazard = bus.id_valid & (sb_q[bus.id_rs1] | sb_q[bus.id_rs2] |
                             (bus.id_uses_rd & sb_q[bus.id_rd]));
    // NOTE: every output is assigned on every path, so no latch is inferred;
    // reset masks them combinationally rather than through a register.
    bus.pipe_wb_ready = rst_n & pipe_gnt;
    bus.mdu_wb_ready  = rst_n & mdu_gnt;
    bus.rf_we         = rst_n & (pipe_gnt | mdu_gnt) & (gnt_rd != 5'd0);
    bus.rf_waddr      = rst_n ? gnt_rd   : 5'd0;
    bus.rf_wdata      = rst_n ? gnt_data : 32'd0;
    bus.hazard_stall  = rst_n & hazard;
    bus.busy_mask     = rst_n ? sb_q : 32'd0;
  end

endmodule
